// File: rtl/ttt_pkg.sv
// Shared encodings for the tic-tac-toe controller: cell values, key codes,
// FSM states and the eight winning line masks.
package ttt_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_X     = 2'b01;
  localparam logic [1:0] CELL_O     = 2'b10;
  localparam logic [1:0] CELL_DRAW  = 2'b11;

  localparam logic [3:0] KEY_START  = 4'd0;
  localparam logic [3:0] KEY_LEFT   = 4'd10;
  localparam logic [3:0] KEY_RIGHT  = 4'd11;

  localparam logic [3:0] MOVE_MAX   = 4'd9;
  localparam int         NUM_LINES  = 8;

  typedef enum logic [1:0] {
    ST_MAIN  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_CHECK = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  // Index 0 is the top row; lower index wins when several lines complete at once.
  localparam logic [NUM_LINES-1:0][8:0] LINE_MASKS = {
    9'b001010100,  // 7: cells 3,5,7
    9'b100010001,  // 6: cells 1,5,9
    9'b100100100,  // 5: cells 3,6,9
    9'b010010010,  // 4: cells 2,5,8
    9'b001001001,  // 3: cells 1,4,7
    9'b111000000,  // 2: cells 7,8,9
    9'b000111000,  // 1: cells 4,5,6
    9'b000000111   // 0: cells 1,2,3
  };

  function automatic logic line_owned(input logic [17:0] brd,
                                      input logic [8:0]  mask,
                                      input logic [1:0]  piece);
    logic ok;
    ok = 1'b1;
    for (int k = 0; k < 9; k++) begin
      if (mask[k] && (brd[2*k +: 2] != piece)) begin
        ok = 1'b0;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/ttt_line_check.sv
// Combinational search for a completed line of one piece; reports the
// lowest-indexed line when several complete together.
module ttt_line_check
  import ttt_pkg::*;
(
  input  logic [17:0] board,
  input  logic [1:0]  piece,
  output logic        hit,
  output logic [8:0]  mask
);

  // Scan from the highest index down so the lowest-indexed hit is kept.
  always_comb begin
    hit  = 1'b0;
    mask = 9'b0;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (line_owned(board, LINE_MASKS[i], piece)) begin
        hit  = 1'b1;
        mask = LINE_MASKS[i];
      end else begin
        hit  = hit;
        mask = mask;
      end
    end
  end

endmodule

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game controller: key-driven FSM holding the board, turn,
// result and display state, all outputs registered.
module ttt_game_ctrl
  import ttt_pkg::*;
#(
  parameter int BLINK_DIV = 25000000,
  parameter int FIRST_O   = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [17:0] board,
  output logic        turn_o,
  output logic        is_main,
  output logic        is_right,
  output logic        game_over,
  output logic [1:0]  winner,
  output logic [8:0]  win_line,
  output logic        blink,
  output logic        illegal
);

  localparam int               BLINK_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic             FIRST_TURN = (FIRST_O != 0) ? 1'b1 : 1'b0;

  state_t             state_r;
  logic [17:0]        board_r;
  logic               turn_o_r;
  logic               is_main_r;
  logic               is_right_r;
  logic               game_over_r;
  logic [1:0]         winner_r;
  logic [8:0]         win_line_r;
  logic               blink_r;
  logic               illegal_r;
  logic [3:0]         move_cnt_r;
  logic [BLINK_W-1:0] blink_cnt_r;

  logic [1:0]         piece_s;
  logic [8:0]         cell_hot_s;
  logic               cell_key_s;
  logic               cell_busy_s;
  logic [17:0]        board_wr_s;
  logic               start_s;
  logic               side_s;
  logic               line_hit_s;
  logic [8:0]         line_mask_s;

  ttt_line_check u_line_check (
    .board (board_r),
    .piece (piece_s),
    .hit   (line_hit_s),
    .mask  (line_mask_s)
  );

  // Decode the key against the board: target cell, occupancy and the board after placement.
  always_comb begin
    piece_s     = turn_o_r ? CELL_O : CELL_X;
    cell_hot_s  = 9'b0;
    cell_busy_s = 1'b0;
    board_wr_s  = board_r;
    for (int k = 0; k < 9; k++) begin
      if (key_code == 4'(k + 1)) begin
        cell_hot_s[k]         = 1'b1;
        cell_busy_s           = (board_r[2*k +: 2] != CELL_EMPTY);
        board_wr_s[2*k +: 2]  = piece_s;
      end else begin
        cell_hot_s[k]         = 1'b0;
      end
    end
    cell_key_s = |cell_hot_s;
    start_s    = key_valid && (key_code == KEY_START) &&
                 ((state_r == ST_MAIN) || (state_r == ST_OVER));
    side_s     = key_valid && ((state_r == ST_PLAY) || (state_r == ST_OVER));
  end

  // Game FSM with all output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= ST_MAIN;
      board_r     <= 18'b0;
      turn_o_r    <= FIRST_TURN;
      is_main_r   <= 1'b1;
      is_right_r  <= 1'b0;
      game_over_r <= 1'b0;
      winner_r    <= CELL_EMPTY;
      win_line_r  <= 9'b0;
      blink_r     <= 1'b0;
      illegal_r   <= 1'b0;
      move_cnt_r  <= 4'd0;
      blink_cnt_r <= '0;
    end else begin
      illegal_r <= 1'b0;
      if (side_s && (key_code == KEY_LEFT)) begin
        is_right_r <= 1'b0;
      end else if (side_s && (key_code == KEY_RIGHT)) begin
        is_right_r <= 1'b1;
      end

      if (start_s) begin
        state_r     <= ST_PLAY;
        board_r     <= 18'b0;
        turn_o_r    <= FIRST_TURN;
        is_main_r   <= 1'b0;
        game_over_r <= 1'b0;
        winner_r    <= CELL_EMPTY;
        win_line_r  <= 9'b0;
        blink_r     <= 1'b0;
        move_cnt_r  <= 4'd0;
        blink_cnt_r <= '0;
      end else begin
        case (state_r)
          ST_MAIN: begin
            state_r <= ST_MAIN;
          end
          ST_PLAY: begin
            if (key_valid && cell_key_s) begin
              if (cell_busy_s) begin
                illegal_r <= 1'b1;
              end else begin
                board_r <= board_wr_s;
                if (move_cnt_r != MOVE_MAX) begin
                  move_cnt_r <= move_cnt_r + 4'd1;
                end
                state_r <= ST_CHECK;
              end
            end
          end
          ST_CHECK: begin
            // Keys arriving here are intentionally ignored.
            if (line_hit_s) begin
              state_r     <= ST_OVER;
              game_over_r <= 1'b1;
              winner_r    <= piece_s;
              win_line_r  <= line_mask_s;
              blink_r     <= 1'b0;
              blink_cnt_r <= '0;
            end else if (move_cnt_r == MOVE_MAX) begin
              state_r     <= ST_OVER;
              game_over_r <= 1'b1;
              winner_r    <= CELL_DRAW;
              win_line_r  <= 9'b0;
              blink_r     <= 1'b0;
              blink_cnt_r <= '0;
            end else begin
              turn_o_r <= ~turn_o_r;
              state_r  <= ST_PLAY;
            end
          end
          ST_OVER: begin
            if (blink_cnt_r == BLINK_LAST) begin
              blink_r     <= ~blink_r;
              blink_cnt_r <= '0;
            end else begin
              blink_cnt_r <= blink_cnt_r + 1'b1;
            end
          end
          default: begin
            state_r     <= ST_MAIN;
            is_main_r   <= 1'b1;
            game_over_r <= 1'b0;
            blink_r     <= 1'b0;
            blink_cnt_r <= '0;
          end
        endcase
      end
    end
  end

  assign board     = board_r;
  assign turn_o    = turn_o_r;
  assign is_main   = is_main_r;
  assign is_right  = is_right_r;
  assign game_over = game_over_r;
  assign winner    = winner_r;
  assign win_line  = win_line_r;
  assign blink     = blink_r;
  assign illegal   = illegal_r;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Bench for ttt_game_ctrl: directed game scenarios followed by random key
// traffic, every cycle checked against a rule-level game model.
module tb_ttt_game_ctrl;

  localparam int BDIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'd0;
  logic [17:0] board;
  logic        turn_o, is_main, is_right, game_over, blink, illegal;
  logic [1:0]  winner;
  logic [8:0]  win_line;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ttt_game_ctrl #(.BLINK_DIV(BDIV), .FIRST_O(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_code  (key_code),
    .board     (board),
    .turn_o    (turn_o),
    .is_main   (is_main),
    .is_right  (is_right),
    .game_over (game_over),
    .winner    (winner),
    .win_line  (win_line),
    .blink     (blink),
    .illegal   (illegal)
  );

  // Reference model: mode 0 = title screen, 1 = awaiting move, 2 = judging, 3 = finished
  int m_mode;
  int m_cells [9];
  bit m_turn, m_right, m_blink, m_illegal;
  int m_winner, m_line, m_bcnt, m_moves;
  int lines [8][3] = '{'{1,2,3}, '{4,5,6}, '{7,8,9}, '{1,4,7},
                       '{2,5,8}, '{3,6,9}, '{1,5,9}, '{3,5,7}};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [17:0] m_board();
    logic [17:0] b;
    b = 18'b0;
    for (int k = 0; k < 9; k++) b[2*k +: 2] = 2'(m_cells[k]);
    return b;
  endfunction

  task automatic model_new_game();
    foreach (m_cells[k]) m_cells[k] = 0;
    m_moves = 0; m_turn = 1'b0; m_winner = 0; m_line = 0;
    m_blink = 1'b0; m_bcnt = 0; m_mode = 1;
  endtask

  task automatic model_reset();
    model_new_game();
    m_mode = 0; m_right = 1'b0; m_illegal = 1'b0;
  endtask

  task automatic model_step(input bit r, input bit kv, input int kc);
    int piece, found;
    if (!r) begin
      model_reset();
      return;
    end
    m_illegal = 1'b0;
    case (m_mode)
      0: if (kv && kc == 0) model_new_game();
      1: if (kv) begin
           if (kc >= 1 && kc <= 9) begin
             if (m_cells[kc-1] != 0) m_illegal = 1'b1;
             else begin
               m_cells[kc-1] = m_turn ? 2 : 1;
               if (m_moves < 9) m_moves++;
               m_mode = 2;
             end
           end else if (kc == 10) m_right = 1'b0;
           else if (kc == 11) m_right = 1'b1;
         end
      2: begin
           piece = m_turn ? 2 : 1;
           found = -1;
           for (int i = 0; i < 8; i++)
             if (found < 0 && m_cells[lines[i][0]-1] == piece &&
                 m_cells[lines[i][1]-1] == piece && m_cells[lines[i][2]-1] == piece)
               found = i;
           if (found >= 0) begin
             m_mode = 3; m_winner = piece; m_blink = 1'b0; m_bcnt = 0;
             m_line = (1 << (lines[found][0]-1)) | (1 << (lines[found][1]-1)) |
                      (1 << (lines[found][2]-1));
           end else if (m_moves == 9) begin
             m_mode = 3; m_winner = 3; m_line = 0; m_blink = 1'b0; m_bcnt = 0;
           end else begin
             m_turn = !m_turn; m_mode = 1;
           end
         end
      default: begin
           if (kv && kc == 0) model_new_game();
           else begin
             if (kv && kc == 10) m_right = 1'b0;
             if (kv && kc == 11) m_right = 1'b1;
             m_bcnt++;
             if (m_bcnt == BDIV) begin
               m_blink = !m_blink;
               m_bcnt = 0;
             end
           end
         end
    endcase
  endtask

  task automatic compare_all();
    check_val("board",     32'(board),     32'(m_board()));
    check_val("turn_o",    32'(turn_o),    32'(m_turn));
    check_val("is_main",   32'(is_main),   32'(m_mode == 0));
    check_val("is_right",  32'(is_right),  32'(m_right));
    check_val("game_over", 32'(game_over), 32'(m_mode == 3));
    check_val("winner",    32'(winner),    32'(m_winner));
    check_val("win_line",  32'(win_line),  32'(m_line));
    check_val("blink",     32'(blink),     32'(m_blink));
    check_val("illegal",   32'(illegal),   32'(m_illegal));
  endtask

  task automatic cycle(input bit r, input bit kv, input int kc);
    @(negedge clk);
    rst = r; key_valid = kv; key_code = 4'(kc);
    @(posedge clk);
    model_step(r, kv, kc);
    #1;
    compare_all();
  endtask

  task automatic play(input int kc);
    cycle(1'b1, 1'b1, kc);
    cycle(1'b1, 1'b0, 0);
  endtask

  initial begin
    int sel, kc;
    bit r, kv;
    model_reset();

    cycle(1'b0, 1'b0, 0);
    cycle(1'b0, 1'b0, 0);
    check_val("rst_is_main", 32'(is_main), 32'd1);

    cycle(1'b1, 1'b1, 0);
    check_val("start_main", 32'(is_main), 32'd0);
    check_val("start_board", 32'(board), 32'd0);
    check_val("start_turn", 32'(turn_o), 32'd0);

    play(1); play(4); play(2); play(5);
    cycle(1'b1, 1'b1, 3);
    cycle(1'b1, 1'b0, 0);
    check_val("row_winner", 32'(winner), 32'd1);
    check_val("row_line", 32'(win_line), 32'h007);
    cycle(1'b1, 1'b1, 6);
    check_val("over_frozen", 32'(board), 32'h00295);

    cycle(1'b0, 1'b0, 0);
    check_val("rst_over_main", 32'(is_main), 32'd1);

    cycle(1'b1, 1'b1, 0);
    play(5);
    cycle(1'b1, 1'b1, 5);
    check_val("illegal_pulse", 32'(illegal), 32'd1);
    check_val("illegal_turn", 32'(turn_o), 32'd1);
    check_val("illegal_cell5", 32'(board[9:8]), 32'd1);
    cycle(1'b1, 1'b0, 0);
    check_val("illegal_end", 32'(illegal), 32'd0);

    cycle(1'b1, 1'b1, 11);
    check_val("right_set", 32'(is_right), 32'd1);
    cycle(1'b1, 1'b1, 10);
    check_val("right_clr", 32'(is_right), 32'd0);

    cycle(1'b1, 1'b1, 1);
    cycle(1'b1, 1'b1, 2);
    check_val("check_drop_cell2", 32'(board[3:2]), 32'd0);
    check_val("check_drop_illegal", 32'(illegal), 32'd0);

    cycle(1'b1, 1'b1, 3);
    cycle(1'b0, 1'b1, 3);
    check_val("rst_check_main", 32'(is_main), 32'd1);
    check_val("rst_check_board", 32'(board), 32'd0);

    cycle(1'b1, 1'b1, 0);
    play(1); play(2); play(3); play(5); play(4); play(6); play(8); play(7);
    cycle(1'b1, 1'b1, 9);
    cycle(1'b1, 1'b0, 0);
    check_val("draw_winner", 32'(winner), 32'd3);
    check_val("draw_line", 32'(win_line), 32'd0);
    for (int i = 1; i <= 12; i++) begin
      cycle(1'b1, 1'b0, 0);
      check_val("blink_phase", 32'(blink), 32'((i / BDIV) % 2));
    end

    for (int n = 0; n < 4000; n++) begin
      r   = ($urandom_range(0, 299) != 0);
      kv  = ($urandom_range(0, 2) == 0);
      sel = $urandom_range(0, 19);
      if (sel < 12)      kc = $urandom_range(1, 9);
      else if (sel < 15) kc = 0;
      else if (sel == 15) kc = 10;
      else if (sel == 16) kc = 11;
      else               kc = $urandom_range(12, 15);
      cycle(r, kv, kc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ttt_game_ctrl.md
TTT_GAME_CTRL -- requirements
Module: ttt_game_ctrl

Interface
REQ-001 SHALL have parameter BLINK_DIV, default 25000000, clk cycles per blink half-period in OVER.
REQ-002 SHALL have parameter FIRST_O, default 0, first mover after start (0 = X, 1 = O).
REQ-003 SHALL have port clk, input, 1, single system clock; all logic on posedge.
REQ-004 SHALL have port rst, input, 1, synchronous active-low reset.
REQ-005 SHALL have port key_valid, input, 1, one-cycle pulse marking a new debounced key.
REQ-006 SHALL have port key_code, input, 4, key identity: 1-9 cell, 0 start, 10 '*', 11 '#'; other codes ignored.
REQ-007 SHALL have port board, output, 18, cell k (1-9) at bits [2k-1:2k-2]; 00 empty, 01 X, 10 O.
REQ-008 SHALL have port turn_o, output, 1, 1 when O is to move.
REQ-009 SHALL have port is_main, output, 1, 1 in MAIN state (press-up screen).
REQ-010 SHALL have port is_right, output, 1, board display offset (1 = right).
REQ-011 SHALL have port game_over, output, 1, 1 in OVER state.
REQ-012 SHALL have port winner, output, 2, 00 none, 01 X, 10 O, 11 draw.
REQ-013 SHALL have port win_line, output, 9, one-hot cell mask of winning line (bit k-1 = cell k).
REQ-014 SHALL have port blink, output, 1, display blink phase, toggles only in OVER.
REQ-015 SHALL have port illegal, output, 1, one-cycle pulse on a rejected cell key.

Function
REQ-016 SHALL implement FSM states MAIN, PLAY, CHECK, OVER.
REQ-017 MAIN: key_valid with code 0 SHALL clear board, set move_cnt=0 and turn_o=FIRST_O, and go to PLAY next cycle; all other keys ignored.
REQ-018 PLAY: key_valid with code 1-9 on an empty cell SHALL write 01 (X) or 10 (O) per turn_o into that cell, increment move_cnt and go to CHECK on the next edge.
REQ-019 PLAY: key_valid with code 1-9 on an occupied cell SHALL leave board unchanged and pulse illegal for exactly one cycle, with the pulse one cycle after the key.
REQ-020 CHECK (exactly one cycle): if any of 8 lines (3 rows, 3 columns, 2 diagonals) holds three cells of the mover's piece, SHALL go to OVER with winner = mover and win_line = that line's mask.
REQ-021 If more than one line wins at once, SHALL report the lowest-indexed line (rows 0-2, cols 3-5, diag 1-5-9 = 6, diag 3-5-7 = 7).
REQ-022 CHECK, no win and move_cnt==9: SHALL go to OVER with winner=11 and win_line=0.
REQ-023 CHECK otherwise: SHALL toggle turn_o and return to PLAY.
REQ-024 key_valid during CHECK SHALL be dropped with no effect and no illegal pulse.
REQ-025 OVER: board SHALL be frozen; key 0 SHALL restart as REQ-017 and clear winner/win_line.
REQ-026 OVER: blink SHALL be 0 on entry and toggle every BLINK_DIV cycles; blink SHALL be 0 in all other states.
REQ-027 Code 10 SHALL clear is_right and code 11 SHALL set it, in PLAY and OVER only, effective the next cycle.
REQ-028 move_cnt SHALL be 4 bits and saturate at 9.
REQ-029 All outputs SHALL be registered, with no combinational path from key inputs to outputs.

Reset
REQ-030 When rst=0 at a clock edge, SHALL enter MAIN with board=0, turn_o=FIRST_O, is_right=0, winner=00, win_line=0, blink=0, illegal=0, move_cnt=0 and the blink counter cleared.
REQ-031 Reset during any state, including CHECK, SHALL override all pending transitions and key inputs.

Structure
REQ-032 Shared package ttt_pkg SHALL hold the cell encodings (EMPTY, X, O), key codes (KEY_START=0, KEY_LEFT=10, KEY_RIGHT=11), FSM state encoding and the 8 line masks.
REQ-033 Line evaluation SHALL be a combinational sub-module ttt_line_check (inputs: board and piece; outputs: hit and a 9-bit mask).

Verification
REQ-034 Reset, then key 0 -> PLAY; is_main=0, board=0, turn_o=0.
REQ-035 X plays 1, O plays 4, X plays 2, O plays 5, X plays 3 -> OVER, winner=01, win_line=9'b000000111, board fixed.
REQ-036 In PLAY, X plays 5, then O presses 5 -> illegal pulses 1 cycle; board[9:8]=01 unchanged; turn_o stays 1.
REQ-037 Sequence 1,2,3,5,4,6,8,7,9 -> OVER, winner=11, win_line=0; with BLINK_DIV=4 blink toggles every 4 cycles.
REQ-038 key 11 then key 10 in PLAY -> is_right goes 1 then 0; key_valid asserted during CHECK -> board unchanged, no illegal.
REQ-039 rst=0 asserted in OVER and in CHECK -> next cycle MAIN with all outputs at reset values.
